// File: rtl/serial_mac_n_if.sv
// ----------------------------------------------------------------------------
// serial_mac_n_if
//   Host-side bundle for the bit-serial multiply-accumulate engine.
//
//   Host -> engine : start, shift_a, shift_b, shift, do_next
//   Engine -> host : shift_out, end_mul, finish, carry_out, busy
//
//   modport master : the host that loads operands and reads the result
//   modport slave  : the serial_mac_n engine
// ----------------------------------------------------------------------------
interface serial_mac_n_if;
  logic start;
  logic shift_a;
  logic shift_b;
  logic shift;
  logic do_next;
  logic shift_out;
  logic end_mul;
  logic finish;
  logic carry_out;
  logic busy;

  modport master (
    output start, shift_a, shift_b, shift, do_next,
    input  shift_out, end_mul, finish, carry_out, busy
  );

  modport slave (
    input  start, shift_a, shift_b, shift, do_next,
    output shift_out, end_mul, finish, carry_out, busy
  );
endinterface

// File: rtl/serial_mac_n.sv
// ----------------------------------------------------------------------------
// serial_mac_n
//   Parametrised bit-serial multiply-accumulate engine. Operand pairs are
//   loaded MSB-first, one bit per rising edge of the shift strobe, multiplied
//   by OP_W cycles of shift-add, and summed into an ACC_W-bit accumulator.
//   After N_TERMS products the accumulator is shifted out LSB-first.
//
// Parameters
//   OP_W    : operand width (>= 2)
//   ACC_W   : accumulator width (>= 2*OP_W)
//   N_TERMS : products per run (>= 1)
//
// Ports
//   clock : sole clock, rising edge
//   reset : synchronous, active-high; clears all state
//   bus   : serial_mac_n_if.slave
//           in : start, shift_a, shift_b, shift, do_next
//           out: shift_out (acc[0]), end_mul (WAIT), finish (DONE),
//                carry_out (sticky overflow), busy (not IDLE)
//
// Build option
//   SERIAL_MAC_SATURATE_EN : when defined, an accumulator overflow loads all
//   ones instead of wrapping. carry_out is sticky in both builds.
// ----------------------------------------------------------------------------
module serial_mac_n #(
  parameter int OP_W    = 8,
  parameter int ACC_W   = 20,
  parameter int N_TERMS = 9
) (
  input logic           clock,
  input logic           reset,
  serial_mac_n_if.slave bus
);

  localparam int TW = $clog2(N_TERMS + 1);
  // Bit counter serves operand load, multiply and result shift-out.
  localparam int BW = $clog2(ACC_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_ACC,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q,    state_d;
  logic                shift_q,    shift_d;
  logic [OP_W-1:0]     a_q,        a_d;
  logic [OP_W-1:0]     b_q,        b_d;
  logic [2*OP_W-1:0]   prod_q,     prod_d;
  logic [ACC_W-1:0]    acc_q,      acc_d;
  logic                carry_q,    carry_d;
  logic [TW-1:0]       term_cnt_q, term_cnt_d;
  logic [BW-1:0]       bit_cnt_q,  bit_cnt_d;

  logic                shift_ev;
  logic [2*OP_W-1:0]   a_ext;
  logic [ACC_W:0]      prod_ext;
  logic [ACC_W:0]      sum;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    shift_d    = bus.shift;
    a_d        = a_q;
    b_d        = b_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    term_cnt_d = term_cnt_q;
    bit_cnt_d  = bit_cnt_q;

    // Rising edge of the level strobe: holding shift high yields one event.
    shift_ev = bus.shift & ~shift_q;

    // Partial product for the current multiplier bit position.
    a_ext = {{OP_W{1'b0}}, a_q} << bit_cnt_q;

    prod_ext                = '0;
    prod_ext[2*OP_W-1:0]    = prod_q;
    sum                     = {1'b0, acc_q} + prod_ext;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d      = '0;
          carry_d    = 1'b0;
          term_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        if (shift_ev) begin
          a_d = {a_q[OP_W-2:0], bus.shift_a};
          b_d = {b_q[OP_W-2:0], bus.shift_b};
          if (bit_cnt_q == BW'(OP_W - 1)) begin
            prod_d    = '0;
            bit_cnt_d = '0;
            state_d   = S_MUL;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

      S_MUL: begin
        // b is consumed LSB-first, so b[0] weights the bit_cnt-th position.
        if (b_q[0]) prod_d = prod_q + a_ext;
        b_d = b_q >> 1;
        if (bit_cnt_q == BW'(OP_W - 1)) begin
          bit_cnt_d = '0;
          state_d   = S_ACC;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end

      S_ACC: begin
        if (sum[ACC_W]) carry_d = 1'b1;
`ifdef SERIAL_MAC_SATURATE_EN
        // Once saturated, every later sum overflows again or adds zero,
        // so the accumulator stays pinned at all ones for the run.
        acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        acc_d = sum[ACC_W-1:0];
`endif
        term_cnt_d = term_cnt_q + TW'(1);
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (bus.do_next) begin
          bit_cnt_d = '0;
          state_d   = (term_cnt_q == TW'(N_TERMS)) ? S_DONE : S_LOAD;
        end
      end

      S_DONE: begin
        if (shift_ev) begin
          acc_d     = acc_q >> 1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(ACC_W - 1)) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      term_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      shift_q    <= shift_d;
      a_q        <= a_d;
      b_q        <= b_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      term_cnt_q <= term_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign bus.shift_out = acc_q[0];
  assign bus.end_mul   = (state_q == S_WAIT);
  assign bus.finish    = (state_q == S_DONE);
  assign bus.carry_out = carry_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_mac_n.sv
// ----------------------------------------------------------------------------
// tb_serial_mac_n
//   Four engines with different parameter sets share one host driver; `sel`
//   routes the host strobes to one engine and its outputs back.
//     sel 0 : OP_W=8,  ACC_W=20, N_TERMS=9
//     sel 1 : OP_W=8,  ACC_W=20, N_TERMS=17
//     sel 2 : OP_W=4,  ACC_W=10, N_TERMS=2
//     sel 3 : OP_W=12, ACC_W=24, N_TERMS=1
// ----------------------------------------------------------------------------
module tb_serial_mac_n;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic shift_a = 1'b0;
  logic shift_b = 1'b0;
  logic shift = 1'b0;
  logic do_next = 1'b0;
  int   sel = 0;

  always #5 clock = ~clock;

  function automatic int op_w_of(int s);
    case (s)
      0, 1:    return 8;
      2:       return 4;
      default: return 12;
    endcase
  endfunction

  function automatic int acc_w_of(int s);
    case (s)
      0, 1:    return 20;
      2:       return 10;
      default: return 24;
    endcase
  endfunction

  function automatic int n_of(int s);
    case (s)
      0:       return 9;
      1:       return 17;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  serial_mac_n_if u_if[4] ();
  logic so_v[4], em_v[4], fi_v[4], co_v[4], bz_v[4];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      assign u_if[g].start   = start & (sel == g);
      assign u_if[g].shift_a = shift_a;
      assign u_if[g].shift_b = shift_b;
      assign u_if[g].shift   = shift & (sel == g);
      assign u_if[g].do_next = do_next & (sel == g);
      assign so_v[g] = u_if[g].shift_out;
      assign em_v[g] = u_if[g].end_mul;
      assign fi_v[g] = u_if[g].finish;
      assign co_v[g] = u_if[g].carry_out;
      assign bz_v[g] = u_if[g].busy;

      serial_mac_n #(
        .OP_W    (op_w_of(g)),
        .ACC_W   (acc_w_of(g)),
        .N_TERMS (n_of(g))
      ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if[g])
      );
    end
  endgenerate

  logic dut_shift_out, dut_end_mul, dut_finish, dut_carry_out, dut_busy;
  assign dut_shift_out = so_v[sel[1:0]];
  assign dut_end_mul   = em_v[sel[1:0]];
  assign dut_finish    = fi_v[sel[1:0]];
  assign dut_carry_out = co_v[sel[1:0]];
  assign dut_busy      = bz_v[sel[1:0]];

  int n_cmp = 0;
  int n_err = 0;
  int cur_op, cur_acc, cur_n;
  int qa[$];
  int qb[$];

  typedef struct {
    int     sel;
    int     a0, b0, ainc, binc;
    longint exp_dout;
    bit     exp_carry;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are read 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic select(input int s);
    sel     = s;
    cur_op  = op_w_of(s);
    cur_acc = acc_w_of(s);
    cur_n   = n_of(s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Shift operand bits first_bit..0; returns right after the edge that
  // captures bit 0 with the strobe already dropped.
  task automatic shift_bits(input int av, input int bv, input int first_bit);
    for (int i = first_bit; i >= 0; i--) begin
      shift_a = av[i];
      shift_b = bv[i];
      shift   = 1'b1;
      tick();
      shift   = 1'b0;
      if (i > 0) tick();
    end
  endtask

  // Load a term and count cycles from the capture edge to end_mul (-1 on
  // timeout). poke_next pulses do_next during the first MUL cycle.
  task automatic load_term(input int av, input int bv, input int first_bit,
                           input bit poke_next, output int lat);
    shift_bits(av, bv, first_bit);
    lat = 0;
    if (poke_next) do_next = 1'b1;
    while (!dut_end_mul && lat < 64) begin
      tick();
      do_next = 1'b0;
      lat++;
    end
    if (!dut_end_mul) lat = -1;
  endtask

  // Shift the accumulator out LSB-first.
  task automatic shift_result(output longint dout);
    dout = 0;
    for (int i = 0; i < cur_acc; i++) begin
      dout = dout | (longint'(dut_shift_out) << i);
      shift = 1'b1;
      tick();
      shift = 1'b0;
      tick();
    end
    check("busy_after_last_shift", dut_busy, 0);
    check("finish_after_last_shift", dut_finish, 0);
  endtask

  // Full run over qa/qb; start_term >= 0 pulses start in that term's WAIT.
  task automatic run_queue(input int start_term, output longint dout, output bit cy);
    int lat;
    dout = -1;
    cy   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", dut_busy, 1);
    for (int t = 0; t < qa.size(); t++) begin
      load_term(qa[t], qb[t], cur_op - 1, 1'b0, lat);
      check("end_mul_latency", lat, cur_op + 1);
      if (lat < 0) begin
        do_reset();
        return;
      end
      if (t == start_term) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_wait_ignored", dut_end_mul, 1);
      end
      do_next = 1'b1;
      tick();
      do_next = 1'b0;
      check("end_mul_fall", dut_end_mul, 0);
      check("finish_after_do_next", dut_finish, (t == qa.size() - 1) ? 1 : 0);
    end
    cy = dut_carry_out;
    shift_result(dout);
  endtask

  // Reference: plain arithmetic over the operand list.
  task automatic model(output longint exp, output bit cy);
    longint acc = 0;
    longint lim = longint'(1) << cur_acc;
    longint s;
    cy = 1'b0;
    for (int t = 0; t < qa.size(); t++) begin
      s = acc + longint'(qa[t]) * longint'(qb[t]);
      if (s >= lim) begin
        cy = 1'b1;
`ifdef SERIAL_MAC_SATURATE_EN
        acc = lim - 1;
`else
        acc = s % lim;
`endif
      end else begin
        acc = s;
      end
    end
    exp = acc;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t   vecs[4];
    longint dout, exp;
    bit     cy, exp_cy;
    int     lat;

    vecs[0] = '{0, 2, 3, 1, 1, 438, 1'b0};
`ifdef SERIAL_MAC_SATURATE_EN
    vecs[1] = '{1, 255, 255, 0, 0, 1048575, 1'b1};
`else
    vecs[1] = '{1, 255, 255, 0, 0, 56849, 1'b1};
`endif
    vecs[2] = '{2, 15, 15, -12, -10, 240, 1'b0};
    vecs[3] = '{3, 4095, 4095, 0, 0, 16769025, 1'b0};

    // Reset state.
    select(0);
    do_reset();
    check("rst_shift_out", dut_shift_out, 0);
    check("rst_end_mul", dut_end_mul, 0);
    check("rst_finish", dut_finish, 0);
    check("rst_carry_out", dut_carry_out, 0);
    check("rst_busy", dut_busy, 0);

    // Reset during MUL cycle 3 of the second term, after acc holds 225.
    select(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_term(15, 15, 3, 1'b0, lat);
    check("mid_mul_lat", lat, 5);
    do_next = 1'b1;
    tick();
    do_next = 1'b0;
    check("acc_lsb_before_reset", dut_shift_out, 1);
    shift_bits(3, 5, 3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_mul_rst_shift_out", dut_shift_out, 0);
    check("mid_mul_rst_busy", dut_busy, 0);
    check("mid_mul_rst_end_mul", dut_end_mul, 0);
    check("mid_mul_rst_carry", dut_carry_out, 0);

    // Table-driven runs (the sel 2 entry is the fresh run after that reset).
    for (int v = 0; v < 4; v++) begin
      select(vecs[v].sel);
      qa.delete();
      qb.delete();
      for (int i = 0; i < cur_n; i++) begin
        qa.push_back(vecs[v].a0 + i * vecs[v].ainc);
        qb.push_back(vecs[v].b0 + i * vecs[v].binc);
      end
      run_queue(-1, dout, cy);
      check($sformatf("vec%0d_dout", v), dout, vecs[v].exp_dout);
      check($sformatf("vec%0d_carry", v), cy, vecs[v].exp_carry);
    end

    // start pulsed in WAIT of term 3 must not disturb the run.
    select(0);
    qa.delete();
    qb.delete();
    for (int i = 0; i < 9; i++) begin
      qa.push_back(i + 2);
      qb.push_back(i + 3);
    end
    run_queue(3, dout, cy);
    check("start_wait_dout", dout, 438);
    check("start_wait_carry", cy, 0);

    // Shift held high for 10 cycles captures one bit; do_next in LOAD and
    // MUL is ignored. A = 0xA5A, B = 0x9C3 (both MSBs are 1).
    select(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    do_next = 1'b1;
    tick();
    do_next = 1'b0;
    check("do_next_in_load_busy", dut_busy, 1);
    shift_a = 1'b1;
    shift_b = 1'b1;
    shift = 1'b1;
    repeat (10) tick();
    shift = 1'b0;
    tick();
    load_term(12'hA5A, 12'h9C3, 10, 1'b1, lat);
    check("hold_shift_latency", lat, 13);
    do_next = 1'b1;
    tick();
    do_next = 1'b0;
    check("hold_shift_finish", dut_finish, 1);
    shift_result(dout);
    check("hold_shift_dout", dout, 64'd2650 * 64'd2499);

    // Random operands against the reference model.
    for (int r = 0; r < 8; r++) begin
      select(r % 4);
      qa.delete();
      qb.delete();
      for (int i = 0; i < cur_n; i++) begin
        qa.push_back(int'($urandom_range((1 << cur_op) - 1, 0)));
        qb.push_back(int'($urandom_range((1 << cur_op) - 1, 0)));
      end
      model(exp, exp_cy);
      run_queue(-1, dout, cy);
      check($sformatf("rand%0d_dout", r), dout, exp);
      check($sformatf("rand%0d_carry", r), cy, exp_cy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
